golden_nonce_uart_tx: RTL and testbench
=======================================

// Module: golden_nonce_uart_tx
// PURPOSE
//  Return path of the miner. Captures each golden_nonce reported by fpgaminer_top on its
//  new_golden_ticket strobe into a small FIFO. Serialises every queued nonce to the host as
//  four UART 8N1 bytes on uart_txd. Sits beside the miner core in the hash_clk domain.
// PARAMETERS
//  CLKS_PER_BIT     434  hash_clk cycles per UART bit; must be >= 2 (elaboration error otherwise)
//  FIFO_DEPTH_LOG2  2    nonce FIFO holds 2**FIFO_DEPTH_LOG2 entries (default 4)
// PORTS
//  hash_clk           in   1                  single clock; all logic samples its rising edge
//  reset_n            in   1                  asynchronous, active-low reset
//  new_golden_ticket  in   1                  capture strobe; golden_nonce valid while high
//  golden_nonce       in   32                 nonce to report
//  uart_txd           out  1                  serial line; idle high
//  tx_busy            out  1                  high while a frame is on the line or FIFO non-empty
//  overflow           out  1                  sticky; a ticket was dropped because the FIFO was full
//  fifo_level         out  FIFO_DEPTH_LOG2+1  number of nonces queued (excludes the one shifting)
// BEHAVIOUR
//  Reset: uart_txd=1, tx_busy=0, overflow=0, fifo_level=0; FIFO, counters and FSM cleared.
//   reset_n low mid-frame forces uart_txd=1 immediately. The partial frame is abandoned.
//  Capture: each cycle new_golden_ticket=1 pushes golden_nonce (back-to-back strobes = multiple pushes).
//   FIFO full and no pop that cycle: push dropped, overflow set (held until reset).
//   Full with a pop the same cycle: push accepted, fifo_level unchanged.
//  FSM states IDLE, START, DATA, STOP. bit_tmr counts CLKS_PER_BIT-1..0.
//   bit_idx counts 0..7. byte_idx counts 0..3.
//   IDLE: FIFO non-empty -> pop into 32-bit shift reg, byte_idx=0, go START.
//   START: txd=0 for one bit period -> DATA.
//   DATA: txd=data bit, LSB first, 8 bit periods -> STOP.
//   STOP: txd=1 for one bit period. Then:
//    byte_idx<3 -> byte_idx++, START (no gap).
//    byte_idx==3 and FIFO non-empty -> pop, START.
//    byte_idx==3 and FIFO empty -> IDLE.
//  Latency: a ticket at edge N into an empty FIFO while IDLE gives uart_txd=0 from edge N+2.
//  One nonce = 40 bit periods = 40*CLKS_PER_BIT cycles. Consecutive nonces have no idle gap.
//  uart_txd is driven from a flop (glitch-free).
//  fifo_level wraps never: it saturates at 2**FIFO_DEPTH_LOG2 by construction.
// CONFIGURATION
//  GOLDEN_TX_BYTESWAP_EN undefined: bytes sent golden_nonce[31:24] first, [7:0] last (big-endian).
//  GOLDEN_TX_BYTESWAP_EN defined: bytes sent [7:0] first, [31:24] last (little-endian).
//   This matches block-explorer nonce order. Bit order within a byte is LSB first either way.
// STRUCTURE
//  golden_tx_pkg: FSM state encoding.
//   Constants BYTES_PER_NONCE=4, DATA_BITS=8, NONCE_W=32.
//  Sub-module golden_nonce_fifo: synchronous FIFO, 32-bit wide, depth 2**FIFO_DEPTH_LOG2.
//   Ports push/pop/full/empty/level. Same hash_clk/reset_n. Pop data valid same cycle as !empty.
//  Top holds the FSM, bit timer, shift register and overflow flag.
// TESTING  (CLKS_PER_BIT=4, FIFO_DEPTH_LOG2=2 unless stated)
//  1 Single ticket, golden_nonce=32'h1DAC2B7C -> line bytes 0x1D,0xAC,0x2B,0x7C.
//    uart_txd=0 from edge N+2. tx_busy falls after 160 cycles.
//  2 Same stimulus with GOLDEN_TX_BYTESWAP_EN -> bytes 0x7C,0x2B,0xAC,0x1D.
//  3 Tickets 32'h00000001, 32'hFFFFFFFF on consecutive cycles -> 8 bytes back-to-back, 320 cycles.
//    No idle bit between the two nonces. overflow=0.
//  4 Six tickets on consecutive cycles (1 in shifter + 4 queued) -> 6th dropped.
//    overflow=1 and stays 1. Exactly 5 nonces emitted. fifo_level peaks at 4.
//  5 Push while full on the cycle the FSM pops -> push accepted, overflow stays 0.
//  6 reset_n low at bit 5 of byte 2 -> uart_txd=1 asynchronously, fifo_level=0.
//    After release, a new ticket 32'hA5A5A5A5 -> clean 4-byte frame.

Source files
------------

// File: rtl/golden_tx_pkg.sv
// golden_tx_pkg: shared types and constants for the golden-nonce UART return path.
// Byte order on the line is selected by GOLDEN_TX_BYTESWAP_EN (see golden_nonce_uart_tx).
package golden_tx_pkg;

    localparam int unsigned BYTES_PER_NONCE = 4;
    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned NONCE_W         = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Reverse the byte order of a nonce word; bit order inside each byte is kept.
    function automatic logic [NONCE_W-1:0] byte_reverse(input logic [NONCE_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/golden_nonce_fifo.sv
// golden_nonce_fifo: show-ahead synchronous FIFO for captured nonces.
// rd_data is valid in the same cycle that empty is low. A push while full is
// accepted only when a pop happens in the same cycle.
module golden_nonce_fifo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  hash_clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned           DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because pointers define validity.
    always_ff @(posedge hash_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/golden_nonce_uart_tx.sv
// golden_nonce_uart_tx: queues golden nonces and sends each as four UART 8N1 bytes.
// Build option GOLDEN_TX_BYTESWAP_EN: when defined, bytes go out [7:0] first
// (little-endian); otherwise [31:24] first (big-endian). Bits are LSB first always.
module golden_nonce_uart_tx
    import golden_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT    = 434,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       hash_clk,
    input  logic                       reset_n,
    input  logic                       new_golden_ticket,
    input  logic [NONCE_W-1:0]         golden_nonce,
    output logic                       uart_txd,
    output logic                       tx_busy,
    output logic                       overflow,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("golden_nonce_uart_tx: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    localparam int unsigned     TMR_W      = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [2:0]       LAST_BIT   = 3'(DATA_BITS - 1);
    localparam logic [1:0]       LAST_BYTE  = 2'(BYTES_PER_NONCE - 1);

    tx_state_t          state;
    tx_state_t          state_nxt;
    logic [TMR_W-1:0]   bit_tmr;
    logic [2:0]         bit_idx;
    logic [1:0]         byte_idx;
    logic [NONCE_W-1:0] shift_reg;
    logic [NONCE_W-1:0] line_word;
    logic               bit_done;
    logic               txd_nxt;

    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [NONCE_W-1:0] fifo_rd_data;

    golden_nonce_fifo #(
        .WIDTH      (NONCE_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .hash_clk (hash_clk),
        .reset_n  (reset_n),
        .push     (new_golden_ticket),
        .wr_data  (golden_nonce),
        .pop      (fifo_pop),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign bit_done = (bit_tmr == '0);

    // The shift register always shifts right and drives bit 0, so the popped word
    // is pre-arranged into line order: first byte in [7:0], its LSB in bit 0.
`ifdef GOLDEN_TX_BYTESWAP_EN
    assign line_word = fifo_rd_data;
`else
    assign line_word = byte_reverse(fifo_rd_data);
`endif

    // FSM state register.
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (!fifo_empty) state_nxt = ST_START;
            ST_START: if (bit_done) state_nxt = ST_DATA;
            ST_DATA:  if (bit_done && (bit_idx == LAST_BIT)) state_nxt = ST_STOP;
            ST_STOP: begin
                if (bit_done) begin
                    if (byte_idx != LAST_BYTE) state_nxt = ST_START;
                    else if (!fifo_empty)      state_nxt = ST_START;
                    else                       state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: FIFO pop and the next value of the serial line.
    always_comb begin
        fifo_pop = 1'b0;
        txd_nxt  = 1'b1;
        unique case (state)
            ST_IDLE: begin
                fifo_pop = !fifo_empty;
                txd_nxt  = 1'b1;
            end
            ST_START: txd_nxt = 1'b0;
            ST_DATA:  txd_nxt = shift_reg[0];
            ST_STOP: begin
                fifo_pop = bit_done && (byte_idx == LAST_BYTE) && !fifo_empty;
                txd_nxt  = 1'b1;
            end
            default: begin
                fifo_pop = 1'b0;
                txd_nxt  = 1'b1;
            end
        endcase
    end

    // Bit timer, bit/byte counters and the nonce shift register.
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_tmr   <= TMR_RELOAD;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shift_reg <= '0;
        end else if (fifo_pop) begin
            bit_tmr   <= TMR_RELOAD;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shift_reg <= line_word;
        end else if (state == ST_IDLE) begin
            bit_tmr   <= TMR_RELOAD;
        end else begin
            bit_tmr <= bit_done ? TMR_RELOAD : (bit_tmr - TMR_ONE);
            if (bit_done && (state == ST_DATA)) begin
                shift_reg <= shift_reg >> 1;
                bit_idx   <= bit_idx + 3'd1;
            end
            if (bit_done && (state == ST_STOP) && (byte_idx != LAST_BYTE)) begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    // Registered line, busy and sticky overflow outputs.
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            uart_txd <= 1'b1;
            tx_busy  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            uart_txd <= txd_nxt;
            tx_busy  <= (state != ST_IDLE) || !fifo_empty;
            if (new_golden_ticket && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// tb_golden_nonce_uart_tx: scoreboard bench for golden_nonce_uart_tx.
// Expected line bytes are queued when a ticket is driven; a UART receiver model
// on the line pops and compares them. Honours GOLDEN_TX_BYTESWAP_EN.
module tb_golden_nonce_uart_tx;

    localparam int unsigned CPB  = 4;
    localparam int unsigned LOG2 = 2;

    logic            hash_clk = 1'b0;
    logic            reset_n;
    logic            new_golden_ticket;
    logic [31:0]     golden_nonce;
    logic            uart_txd;
    logic            tx_busy;
    logic            overflow;
    logic [LOG2:0]   fifo_level;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_bytes = 0;
    logic [7:0]  exp_q[$];

    bit          mon_active = 1'b0;
    int unsigned mon_cnt = 0;
    logic [7:0]  mon_byte = '0;

    always #5 hash_clk = ~hash_clk;

    golden_nonce_uart_tx #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG2 (LOG2)
    ) dut (
        .hash_clk          (hash_clk),
        .reset_n           (reset_n),
        .new_golden_ticket (new_golden_ticket),
        .golden_nonce      (golden_nonce),
        .uart_txd          (uart_txd),
        .tx_busy           (tx_busy),
        .overflow          (overflow),
        .fifo_level        (fifo_level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte i (0 = first on the line) of a nonce.
    function automatic logic [7:0] line_byte(input logic [31:0] n, input int unsigned i);
`ifdef GOLDEN_TX_BYTESWAP_EN
        return n[8*i +: 8];
`else
        return n[8*(3-i) +: 8];
`endif
    endfunction

    // UART receiver: start detected at a falling edge sample, then mid-bit sampling.
    always @(negedge hash_clk) begin
        if (!reset_n) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (uart_txd === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == CPB/2) begin
                check("start_bit", 32'(uart_txd), 32'd0);
            end else if (mon_cnt == CPB/2 + 9*CPB) begin
                check("stop_bit", 32'(uart_txd), 32'd1);
                check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("rx_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                n_bytes++;
                mon_active = 1'b0;
            end else if (mon_cnt > CPB/2 && ((mon_cnt - CPB/2) % CPB) == 0) begin
                mon_byte = {uart_txd, mon_byte[7:1]};
            end
        end
    end

    // Drive one ticket for a single cycle; returns half a cycle after the sampling edge.
    task automatic ticket(input logic [31:0] n, input bit accepted);
        golden_nonce      = n;
        new_golden_ticket = 1'b1;
        if (accepted) begin
            for (int unsigned i = 0; i < 4; i++) exp_q.push_back(line_byte(n, i));
        end
        @(negedge hash_clk);
        new_golden_ticket = 1'b0;
    endtask

    task automatic wait_neg(input int unsigned k);
        repeat (k) @(negedge hash_clk);
    endtask

    // Wait (bounded) until the line is quiet and every expected byte has been seen.
    task automatic drain(input string tag, input int unsigned budget);
        int unsigned k = 0;
        while ((tx_busy || mon_active || exp_q.size() != 0) && k < budget) begin
            @(negedge hash_clk);
            k++;
        end
        check({tag, "_drained"}, 32'(!(tx_busy || mon_active || exp_q.size() != 0)), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int exp_lvl[6];
        exp_lvl = '{1, 1, 2, 3, 4, 4};

        reset_n           = 1'b0;
        new_golden_ticket = 1'b0;
        golden_nonce      = '0;
        wait_neg(3);
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        reset_n = 1'b1;
        wait_neg(2);

        // Single ticket: latency and busy duration.
        ticket(32'h1DAC2B7C, 1'b1);
        check("t1_level", 32'(fifo_level), 32'd1);
        check("t1_txd_n0", 32'(uart_txd), 32'd1);
        wait_neg(1);
        check("t1_txd_n1", 32'(uart_txd), 32'd1);
        check("t1_busy_n1", 32'(tx_busy), 32'd1);
        wait_neg(1);
        check("t1_txd_n2", 32'(uart_txd), 32'd0);
        wait_neg(159);
        check("t1_busy_last", 32'(tx_busy), 32'd1);
        wait_neg(1);
        check("t1_busy_fall", 32'(tx_busy), 32'd0);
        drain("t1", 100);

        // Two back-to-back tickets: 320 cycles with no idle gap.
        wait_neg(3);
        ticket(32'h00000001, 1'b1);
        ticket(32'hFFFFFFFF, 1'b1);
        wait_neg(320);
        check("t3_busy_last", 32'(tx_busy), 32'd1);
        wait_neg(1);
        check("t3_busy_fall", 32'(tx_busy), 32'd0);
        check("t3_ovf", 32'(overflow), 32'd0);
        drain("t3", 100);

        // Six tickets: sixth dropped, overflow sticky.
        wait_neg(3);
        b0 = n_bytes;
        for (int unsigned k = 0; k < 6; k++) begin
            ticket(32'hC0DE0000 + 32'(k), k < 5);
            check($sformatf("t4_level_%0d", k), 32'(fifo_level), 32'(exp_lvl[k]));
        end
        check("t4_ovf_set", 32'(overflow), 32'd1);
        drain("t4", 1200);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);
        check("t4_bytes", 32'(n_bytes - b0), 32'd20);

        // Reset clears the sticky flag asynchronously.
        reset_n = 1'b0;
        #1;
        check("t4_rst_ovf", 32'(overflow), 32'd0);
        @(negedge hash_clk);
        reset_n = 1'b1;
        wait_neg(2);

        // Push while full on the pop cycle is accepted.
        b0 = n_bytes;
        for (int unsigned k = 0; k < 5; k++) ticket(32'h5A000000 + 32'(k), 1'b1);
        check("t5_full", 32'(fifo_level), 32'd4);
        wait_neg(156);
        check("t5_full_prepop", 32'(fifo_level), 32'd4);
        ticket(32'h5A5A5A5A, 1'b1);
        check("t5_level_pop_push", 32'(fifo_level), 32'd4);
        check("t5_ovf", 32'(overflow), 32'd0);
        drain("t5", 1400);
        check("t5_ovf_end", 32'(overflow), 32'd0);
        check("t5_bytes", 32'(n_bytes - b0), 32'd24);

        // Reset mid-frame at bit 5 of byte 2.
        wait_neg(3);
        ticket(32'h00000000, 1'b1);
        ticket(32'h12345678, 1'b1);
        check("t6_level", 32'(fifo_level), 32'd1);
        wait_neg(106);
        check("t6_txd_pre", 32'(uart_txd), 32'd0);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_txd_rst", 32'(uart_txd), 32'd1);
        check("t6_level_rst", 32'(fifo_level), 32'd0);
        check("t6_busy_rst", 32'(tx_busy), 32'd0);
        wait_neg(2);
        reset_n = 1'b1;
        wait_neg(2);
        b0 = n_bytes;
        ticket(32'hA5A5A5A5, 1'b1);
        drain("t6", 300);
        check("t6_bytes", 32'(n_bytes - b0), 32'd4);
        check("t6_txd_idle", 32'(uart_txd), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
